wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback stage plus architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs, aligns and extends load data, and selects the writeback value. It commits that value to a 32x32 register file, serves the two ID-stage read ports with same-cycle write bypass, and exports a WB forwarding tap for the EX forwarding unit plus a committed-writeback counter.

Parameters:
- BYPASS_EN, 1, 1 = read ports return the in-flight WB value when the addresses match; 0 = raw array read.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- alu_res_in  in  32  ALU result from MEM/WB; also the load address, so [1:0] is the byte offset
- mem_data_in  in  32  raw aligned word from data memory
- rd_in  in  5  destination register
- reg_we_in  in  1  register write enable
- mem_to_reg_in  in  1  1 = write load data, 0 = write ALU result
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 word
- load_unsigned_in  in  1  1 = zero-extend, 0 = sign-extend
- rs1_addr  in  5  ID read address 1
- rs2_addr  in  5  ID read address 2
- rs1_data  out  32  read data 1
- rs2_data  out  32  read data 2
- fwd_we  out  1  WB forwarding valid
- fwd_rd  out  5  WB forwarding destination
- fwd_data  out  32  WB forwarding value
- retire_cnt  out  CNT_W  count of committed register writes

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Load extract is combinational. off = alu_res_in[1:0].
  - Byte: mem_data_in[8*off+7:8*off].
  - Half: alu_res_in[1] selects [31:16] or [15:0]; bit 0 is ignored (misaligned half is not trapped here).
  - Word and size 11: full word.
  - Sign or zero extension to 32 bits per load_unsigned_in.
- wb_data = mem_to_reg_in ? extracted : alu_res_in.
- commit = reg_we_in && rd_in != 0 && !reset.
- Register write: on posedge clk, when commit, regs[rd_in] <= wb_data. Visible to the raw array read the next cycle (1-cycle latency).
- x0: never written; reads of address 0 always return 0.
- Read ports are combinational. rsN_data =
  - 0 if reset or rsN_addr == 0;
  - else wb_data if BYPASS_EN and commit and rd_in == rsN_addr;
  - else regs[rsN_addr].
- Both ports may hit the bypass simultaneously, including rs1_addr == rs2_addr.
- Forwarding tap (combinational, zero latency):
  - fwd_we = commit.
  - fwd_rd = rd_in.
  - fwd_data = wb_data.
  - When fwd_we = 0, fwd_rd/fwd_data are don't-care; the forwarding unit must gate on fwd_we.
- retire_cnt: increments by 1 on every posedge with commit; wraps modulo 2^CNT_W with no saturation.
- Reset, synchronous: clears all 32 registers and retire_cnt to 0 in one cycle.
  - While reset is high: rs1_data = rs2_data = 0, fwd_we = 0, and no write occurs even if reg_we_in = 1.
  - Reset asserted mid-stream discards the in-flight WB write.
- No stall input. MEM/WB holds values during a stall, and a repeated write of the same value is harmless. retire_cnt over-counts in that case, so the upstream stage must insert a bubble (reg_we_in = 0) on stall.

Decomposition:
- Shared package constants:
  - LD_BYTE, LD_HALF, LD_WORD encodings;
  - XLEN = 32;
  - REG_ADDR_W = 5.
- One natural sub-module: load_align (combinational extract and extend: mem_data_in, off, size, unsigned -> 32-bit value).
- Register array, bypass and counter stay in wb_regfile.

Test Plan:
1. Reset, then write: reset 2 cycles; reg_we=1, rd=5, mem_to_reg=0, alu_res=0xDEADBEEF. Required: fwd_we=1, fwd_data=0xDEADBEEF in the same cycle; rs1_addr=5 returns 0xDEADBEEF in the same cycle (bypass) and the next cycle (array); retire_cnt=1.
2. Byte and half loads, mem_data=0x80FF7F01, mem_to_reg=1, writes to rd=1..4:
   - byte off=3 signed -> 0xFFFFFF80;
   - byte off=2 unsigned -> 0x000000FF;
   - half off=2 signed -> 0xFFFF80FF;
   - half off=0 unsigned -> 0x00007F01.
3. x0 write: reg_we=1, rd=0, alu_res=0x1234. Required: fwd_we=0; rs1_addr=0 and rs2_addr=0 return 0; retire_cnt unchanged.
4. Dual bypass: rd=7 writing 0xA5A5A5A5 while rs1_addr=rs2_addr=7 holds old value 0x11. Required: both ports return 0xA5A5A5A5 in the same cycle. With BYPASS_EN=0 both return 0x11, then 0xA5A5A5A5 next cycle.
5. Reset mid-operation: regs populated, reset=1 coincident with reg_we=1, rd=9. Required: rs data 0 and fwd_we=0 during reset; after release every register reads 0 and retire_cnt=0.
6. Counter wrap: CNT_W=4, 17 consecutive commits -> retire_cnt=1.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage: data width, register address width and load size encodings.
// Pure constants; no latency or backpressure of its own.
package wb_regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;
endpackage

// File: rtl/wb_regfile_load_align.sv
// Load data extract and sign/zero extension from the raw memory word.
// Purely combinational, zero latency; no backpressure.
module wb_regfile_load_align
  import wb_regfile_pkg::*;
(
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_data[7:0];
    case (off)
      2'd0:    byte_v = mem_data[7:0];
      2'd1:    byte_v = mem_data[15:8];
      2'd2:    byte_v = mem_data[23:16];
      default: byte_v = mem_data[31:24];
    endcase
    // Misaligned halves are not trapped here; off[0] is simply ignored.
    half_v = off[1] ? mem_data[31:16] : mem_data[15:0];
  end

  always_comb begin
    data = mem_data;
    case (size)
      LD_BYTE: data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      LD_HALF: data = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback select, 32x32 register file with same-cycle read bypass, WB forwarding tap and retire counter.
// Writes visible to the array one cycle later; reads and tap are combinational; no backpressure (no stall input).
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       alu_res_in,
  input  logic [XLEN-1:0]       mem_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_we_in,
  input  logic                  mem_to_reg_in,
  input  logic [1:0]            load_size_in,
  input  logic                  load_unsigned_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  fwd_we,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;
  logic            commit;

  wb_regfile_load_align u_load_align (
    .mem_data    (mem_data_in),
    .off         (alu_res_in[1:0]),
    .size        (load_size_in),
    .is_unsigned (load_unsigned_in),
    .data        (load_data)
  );

  assign wb_data = mem_to_reg_in ? load_data : alu_res_in;
  assign commit  = reg_we_in && (rd_in != '0) && !reset;

  assign fwd_we   = commit;
  assign fwd_rd   = rd_in;
  assign fwd_data = wb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      retire_cnt <= '0;
    end else if (commit) begin
      regs[rd_in] <= wb_data;
      retire_cnt  <= retire_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    if (reset || rs1_addr == '0)
      rs1_data = '0;
    else if (BYPASS_EN && commit && rd_in == rs1_addr)
      rs1_data = wb_data;
    else
      rs1_data = regs[rs1_addr];
  end

  always_comb begin
    if (reset || rs2_addr == '0)
      rs2_data = '0;
    else if (BYPASS_EN && commit && rd_in == rs2_addr)
      rs2_data = wb_data;
    else
      rs2_data = regs[rs2_addr];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench: three instances share inputs (default, no-bypass, 4-bit counter).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_res_in, mem_data_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic        reg_we_in, mem_to_reg_in, load_unsigned_in;
  logic [1:0]  load_size_in;

  logic [31:0] a_rs1, a_rs2, a_fwd_data, a_cnt;
  logic        a_fwd_we;
  logic [4:0]  a_fwd_rd;
  logic [31:0] b_rs1, b_rs2, b_fwd_data, b_cnt;
  logic        b_fwd_we;
  logic [4:0]  b_fwd_rd;
  logic [31:0] c_rs1, c_rs2, c_fwd_data;
  logic [3:0]  c_cnt;
  logic        c_fwd_we;
  logic [4:0]  c_fwd_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .alu_res_in(alu_res_in), .mem_data_in(mem_data_in),
    .rd_in(rd_in), .reg_we_in(reg_we_in), .mem_to_reg_in(mem_to_reg_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(a_rs1), .rs2_data(a_rs2),
    .fwd_we(a_fwd_we), .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data), .retire_cnt(a_cnt)
  );

  wb_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .alu_res_in(alu_res_in), .mem_data_in(mem_data_in),
    .rd_in(rd_in), .reg_we_in(reg_we_in), .mem_to_reg_in(mem_to_reg_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b_rs1), .rs2_data(b_rs2),
    .fwd_we(b_fwd_we), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data), .retire_cnt(b_cnt)
  );

  wb_regfile #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .alu_res_in(alu_res_in), .mem_data_in(mem_data_in),
    .rd_in(rd_in), .reg_we_in(reg_we_in), .mem_to_reg_in(mem_to_reg_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(c_rs1), .rs2_data(c_rs2),
    .fwd_we(c_fwd_we), .fwd_rd(c_fwd_rd), .fwd_data(c_fwd_data), .retire_cnt(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] alu,
                    input logic m2r, input logic [1:0] sz, input logic uns);
    reg_we_in        = we;
    rd_in            = rd;
    alu_res_in       = alu;
    mem_to_reg_in    = m2r;
    load_size_in     = sz;
    load_unsigned_in = uns;
  endtask

  logic [4:0]  ld_rd   [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd8};
  logic [31:0] ld_alu  [5] = '{32'd3, 32'd2, 32'd2, 32'd0, 32'd1};
  logic [1:0]  ld_sz   [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
  logic        ld_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F};

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    mem_data_in = 32'h0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    wb(1'b1, 5'd5, 32'h55, 1'b0, 2'b10, 1'b0);
    #2;
    tick();
    chk("reset_rs1", a_rs1, 32'h0);
    chk("reset_fwd_we", {31'b0, a_fwd_we}, 32'h0);
    tick();

    // Test 1: first write after reset, bypass then array.
    reset = 1'b0;
    wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'b10, 1'b0);
    chk("reset_cnt", a_cnt, 32'd0);
    #1;
    chk("t1_fwd_we", {31'b0, a_fwd_we}, 32'h1);
    chk("t1_fwd_rd", {27'b0, a_fwd_rd}, 32'd5);
    chk("t1_fwd_data", a_fwd_data, 32'hDEADBEEF);
    chk("t1_rs1_bypass", a_rs1, 32'hDEADBEEF);
    chk("t1_nb_rs1_raw", b_rs1, 32'h0);
    tick();
    reg_we_in = 1'b0;
    #1;
    chk("t1_rs1_array", a_rs1, 32'hDEADBEEF);
    chk("t1_nb_rs1_array", b_rs1, 32'hDEADBEEF);
    chk("t1_cnt", a_cnt, 32'd1);

    // Test 2: byte/half loads.
    mem_data_in = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      wb(1'b1, ld_rd[i], ld_alu[i], 1'b1, ld_sz[i], ld_uns[i]);
      #1;
      chk($sformatf("t2_fwd_data_%0d", i), a_fwd_data, ld_exp[i]);
      tick();
    end
    wb(1'b0, 5'd0, 32'h0, 1'b0, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rs1_addr = ld_rd[i];
      rs2_addr = ld_rd[4 - i];
      #1;
      chk($sformatf("t2_rs1_%0d", i), a_rs1, ld_exp[i]);
      chk($sformatf("t2_rs2_%0d", i), a_rs2, ld_exp[4 - i]);
    end
    chk("t2_cnt", a_cnt, 32'd6);

    // Test 3: x0 write is dropped.
    wb(1'b1, 5'd0, 32'h1234, 1'b0, 2'b10, 1'b0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    chk("t3_fwd_we", {31'b0, a_fwd_we}, 32'h0);
    chk("t3_rs1", a_rs1, 32'h0);
    chk("t3_rs2", a_rs2, 32'h0);
    tick();
    reg_we_in = 1'b0;
    #1;
    chk("t3_rs1_after", a_rs1, 32'h0);
    chk("t3_cnt", a_cnt, 32'd6);

    // Test 4: dual bypass on the same address.
    wb(1'b1, 5'd7, 32'h11, 1'b0, 2'b10, 1'b0);
    tick();
    wb(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 2'b10, 1'b0);
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    chk("t4_rs1_bypass", a_rs1, 32'hA5A5A5A5);
    chk("t4_rs2_bypass", a_rs2, 32'hA5A5A5A5);
    chk("t4_nb_rs1_old", b_rs1, 32'h11);
    chk("t4_nb_rs2_old", b_rs2, 32'h11);
    tick();
    reg_we_in = 1'b0;
    #1;
    chk("t4_nb_rs1_new", b_rs1, 32'hA5A5A5A5);
    chk("t4_nb_rs2_new", b_rs2, 32'hA5A5A5A5);
    chk("t4_cnt", a_cnt, 32'd8);

    // Test 5: reset coincident with a write.
    reset = 1'b1;
    wb(1'b1, 5'd9, 32'h99, 1'b0, 2'b10, 1'b0);
    rs1_addr = 5'd7;
    rs2_addr = 5'd1;
    #1;
    chk("t5_rs1_in_reset", a_rs1, 32'h0);
    chk("t5_rs2_in_reset", a_rs2, 32'h0);
    chk("t5_fwd_we_in_reset", {31'b0, a_fwd_we}, 32'h0);
    tick();
    reset = 1'b0;
    reg_we_in = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("t5_rs1_r%0d", i), a_rs1, 32'h0);
      chk($sformatf("t5_nb_rs2_r%0d", 31 - i), b_rs2, 32'h0);
    end
    chk("t5_cnt", a_cnt, 32'd0);
    chk("t5_c4_cnt", {28'b0, c_cnt}, 32'd0);

    // Test 6: 17 commits wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      wb(1'b1, 5'd10, 32'(i), 1'b0, 2'b10, 1'b0);
      tick();
    end
    reg_we_in = 1'b0;
    #1;
    chk("t6_c4_cnt_wrap", {28'b0, c_cnt}, 32'd1);
    chk("t6_cnt", a_cnt, 32'd17);
    rs1_addr = 5'd10;
    #1;
    chk("t6_rs1_last", a_rs1, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
